// File: rtl/btn_debounce_rate_sel.sv
// btn_debounce_rate_sel
//   Conditions a raw, bouncing push-button: 2-FF synchronizer, debounce FSM that
//   produces a clean level plus 1-cycle press/release pulses, and a wrapping
//   rate-select code advanced on every press for the downstream blink stage.
//
//   Optional feature macro: LONG_PRESS_EN
//     defined   : holding the button LP_CNT cycles in PRESSED emits one long_press
//                 pulse and forces rate_sel back to 0.
//     undefined : long_press is tied to 0.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   btn_in       in   raw button pin (asynchronous)
//   btn_level    out  debounced level, 1 = pressed
//   btn_press    out  1-cycle pulse on debounced press
//   btn_release  out  1-cycle pulse on debounced release
//   rate_sel     out  current rate code, 0..NUM_RATES-1
//   long_press   out  1-cycle pulse on long press
//
// States
//   S_RELEASED | stable released
//   S_WAIT_P   | pressed level seen, qualifying for DB_CNT cycles
//   S_PRESSED  | stable pressed
//   S_WAIT_R   | released level seen, qualifying for DB_CNT cycles
module btn_debounce_rate_sel #(
    parameter int CLK_HZ      = 25000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int ACTIVE_LOW  = 1,
    parameter int NUM_RATES   = 4,
    parameter int LONG_MS     = 1000,
    localparam int RW         = $clog2(NUM_RATES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_in,
    output logic          btn_level,
    output logic          btn_press,
    output logic          btn_release,
    output logic [RW-1:0] rate_sel,
    output logic          long_press
);

    localparam int DB_CNT = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LP_CNT = CLK_HZ / 1000 * LONG_MS;
    localparam int CW     = $clog2(DB_CNT + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CNT - 1);
    localparam logic [RW-1:0] RATE_MAX = RW'(NUM_RATES - 1);
    localparam logic          IDLE_LVL = (ACTIVE_LOW != 0);

    localparam logic [1:0] S_RELEASED = 2'd0;
    localparam logic [1:0] S_WAIT_P   = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_WAIT_R   = 2'd3;

    // The qualification counter starts at 1 on entry to a WAIT state, so
    // DB_CNT must be at least 2; the long-press arm compare needs LP_CNT >= 3.
    if (NUM_RATES < 2 || DB_CNT < 2 || LP_CNT < 3) begin : g_param_check
        $error("btn_debounce_rate_sel: NUM_RATES>=2, DB_CNT>=2, LP_CNT>=3 required");
    end

    logic          ff1, ff2;
    logic          p;
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // Synchronizer resets to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1 <= IDLE_LVL;
            ff2 <= IDLE_LVL;
        end else begin
            ff1 <= btn_in;
            ff2 <= ff1;
        end
    end

    assign p = ff2 ^ IDLE_LVL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RELEASED;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            case (state)
                S_RELEASED: begin
                    if (p) begin
                        state <= S_WAIT_P;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                S_WAIT_P: begin
                    if (!p) begin
                        state <= S_RELEASED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= S_PRESSED;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PRESSED: begin
                    if (!p) begin
                        state <= S_WAIT_R;
                        cnt   <= CW'(1);
                    end
                end
                S_WAIT_R: begin
                    if (p) begin
                        state <= S_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state       <= S_RELEASED;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef LONG_PRESS_EN
    localparam int LPW = $clog2(LP_CNT);
    localparam logic [LPW-1:0] LP_LAST = LPW'(LP_CNT - 1);
    localparam logic [LPW-1:0] LP_ARM  = LPW'(LP_CNT - 2);

    logic [LPW-1:0] lp_cnt;
    logic           long_q;

    // lp_cnt saturates at LP_LAST, so the arm value is passed exactly once per hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lp_cnt <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (state == S_PRESSED) begin
                if (lp_cnt != LP_LAST) begin
                    lp_cnt <= lp_cnt + LPW'(1);
                end
                if (lp_cnt == LP_ARM) begin
                    long_q <= 1'b1;
                end
            end else begin
                lp_cnt <= '0;
            end
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_sel <= '0;
        end else begin
`ifdef LONG_PRESS_EN
            if (long_press) begin
                rate_sel <= '0;
            end else
`endif
            if (btn_press) begin
                rate_sel <= (rate_sel == RATE_MAX) ? '0 : rate_sel + RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce_rate_sel.sv
// Directed bench for btn_debounce_rate_sel with DB_CNT=5, LP_CNT=20,
// active-low pin, four rate codes. Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge.
module tb_btn_debounce_rate_sel;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic [1:0] rate_sel;
    logic       long_press;

    int errors = 0;
    int checks = 0;

    // Observations gathered by hold()
    int np, fp, nr, fr, nl, fl, nlev, both_total;

    always #5 clk = ~clk;

    btn_debounce_rate_sel #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (5),
        .ACTIVE_LOW  (1),
        .NUM_RATES   (4),
        .LONG_MS     (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .rate_sel    (rate_sel),
        .long_press  (long_press)
    );

    // Drive btn_in to lvl for n cycles, recording pulse counts and the
    // falling-edge index (1-based) of the first pulse of each kind.
    task automatic hold(input logic lvl, input int n);
        btn_in = lvl;
        np = 0; fp = -1; nr = 0; fr = -1; nl = 0; fl = -1; nlev = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (btn_press)   begin np++; if (fp < 0) fp = i; end
            if (btn_release) begin nr++; if (fr < 0) fr = i; end
            if (long_press)  begin nl++; if (fl < 0) fl = i; end
            if (btn_level)   nlev++;
            if (btn_press && btn_release) both_total++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_in = 1'b1;
        both_total = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({btn_level, btn_press, btn_release, rate_sel, long_press} !== 6'b0)
            begin errors++; $display("FAIL reset_values got=%b want=000000",
                {btn_level, btn_press, btn_release, rate_sel, long_press}); end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({btn_level, btn_press, btn_release, rate_sel, long_press} !== 6'b0)
                begin errors++; $display("FAIL idle_quiet cycle=%0d got=%b want=000000", i,
                    {btn_level, btn_press, btn_release, rate_sel, long_press}); end
        end
    endtask

    task automatic test_press();
        hold(1'b0, 12);
        checks++; if (np !== 1) begin errors++; $display("FAIL press_count got=%0d want=1", np); end
        checks++; if (fp !== 7) begin errors++; $display("FAIL press_latency got=%0d want=7", fp); end
        checks++; if (nlev !== 6) begin errors++; $display("FAIL level_cycles got=%0d want=6", nlev); end
        checks++; if (rate_sel !== 2'd1) begin errors++; $display("FAIL press_rate got=%0d want=1", rate_sel); end
        hold(1'b1, 12);
        checks++; if (nr !== 1) begin errors++; $display("FAIL release_count got=%0d want=1", nr); end
        checks++; if (fr !== 7) begin errors++; $display("FAIL release_latency got=%0d want=7", fr); end
        checks++; if (btn_level !== 1'b0) begin errors++; $display("FAIL release_level got=%b want=0", btn_level); end
        checks++; if (rate_sel !== 2'd1) begin errors++; $display("FAIL release_rate got=%0d want=1", rate_sel); end
    endtask

    task automatic test_bounce();
        int tot_p, tot_lev;
        tot_p = 0; tot_lev = 0;
        hold(1'b0, 3); tot_p += np; tot_lev += nlev;
        hold(1'b1, 2); tot_p += np; tot_lev += nlev;
        hold(1'b0, 3); tot_p += np; tot_lev += nlev;
        hold(1'b1, 12); tot_p += np; tot_lev += nlev;
        checks++; if (tot_p !== 0) begin errors++; $display("FAIL bounce_press got=%0d want=0", tot_p); end
        checks++; if (tot_lev !== 0) begin errors++; $display("FAIL bounce_level got=%0d want=0", tot_lev); end
        checks++; if (rate_sel !== 2'd1) begin errors++; $display("FAIL bounce_rate got=%0d want=1", rate_sel); end
    endtask

    task automatic test_rate_wrap();
        logic [1:0] exp_rate [5];
        exp_rate = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rate_sel !== 2'd0) begin errors++; $display("FAIL wrap_reset_rate got=%0d want=0", rate_sel); end
        for (int k = 0; k < 5; k++) begin
            hold(1'b0, 10);
            checks++; if (np !== 1) begin errors++; $display("FAIL wrap_press[%0d] got=%0d want=1", k, np); end
            checks++; if (rate_sel !== exp_rate[k])
                begin errors++; $display("FAIL wrap_rate[%0d] got=%0d want=%0d", k, rate_sel, exp_rate[k]); end
            hold(1'b1, 10);
            checks++; if (nr !== 1 || np !== 0)
                begin errors++; $display("FAIL wrap_release[%0d] got rel=%0d press=%0d want rel=1 press=0", k, nr, np); end
        end
    endtask

    task automatic test_reset_mid();
        hold(1'b0, 5);
        checks++; if (np !== 0) begin errors++; $display("FAIL mid_no_press got=%0d want=0", np); end
        rst = 1'b1;
        hold(1'b0, 2);
        checks++; if ({btn_level, btn_press, btn_release, rate_sel, long_press} !== 6'b0)
            begin errors++; $display("FAIL mid_reset_outputs got=%b want=000000",
                {btn_level, btn_press, btn_release, rate_sel, long_press}); end
        rst = 1'b0;
        hold(1'b0, 12);
        checks++; if (np !== 1 || fp !== 7)
            begin errors++; $display("FAIL mid_requalify got count=%0d at=%0d want count=1 at=7", np, fp); end
        checks++; if (rate_sel !== 2'd1) begin errors++; $display("FAIL mid_rate got=%0d want=1", rate_sel); end
        hold(1'b1, 12);
        checks++; if (nr !== 1) begin errors++; $display("FAIL mid_release got=%0d want=1", nr); end
    endtask

    task automatic test_long_press();
        hold(1'b0, 10);
        hold(1'b1, 10);
        checks++; if (rate_sel !== 2'd2) begin errors++; $display("FAIL long_start_rate got=%0d want=2", rate_sel); end
        hold(1'b0, 30);
        checks++; if (np !== 1 || fp !== 7)
            begin errors++; $display("FAIL long_hold_press got count=%0d at=%0d want count=1 at=7", np, fp); end
        checks++; if (btn_level !== 1'b1) begin errors++; $display("FAIL long_hold_level got=%b want=1", btn_level); end
`ifdef LONG_PRESS_EN
        checks++; if (nl !== 1 || fl !== 26)
            begin errors++; $display("FAIL long_pulse got count=%0d at=%0d want count=1 at=26", nl, fl); end
        checks++; if (rate_sel !== 2'd0) begin errors++; $display("FAIL long_rate got=%0d want=0", rate_sel); end
`else
        checks++; if (nl !== 0) begin errors++; $display("FAIL long_tied_off got=%0d want=0", nl); end
        checks++; if (rate_sel !== 2'd3) begin errors++; $display("FAIL long_rate got=%0d want=3", rate_sel); end
`endif
        hold(1'b1, 12);
        checks++; if (nr !== 1) begin errors++; $display("FAIL long_release got=%0d want=1", nr); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_rate_wrap();
        test_reset_mid();
        test_long_press();
        checks++;
        if (both_total !== 0) begin errors++; $display("FAIL press_release_overlap got=%0d want=0", both_total); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
